// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter fed by a small TX FIFO.
// Frame: start, DATA_BITS data (LSB first), optional parity, 1 or 2 stop bits.
// Line outputs are registered one cycle behind the FSM state, so the start bit
// shows two clocks after a push into an empty, idle block.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CPB_W      = 16
) (
  input  logic                        i_Clock,
  input  logic                        i_Rst_L,
  input  logic                        i_TX_DV,
  input  logic [DATA_BITS-1:0]        i_TX_Byte,
  output logic                        o_TX_Ready,
  input  logic [CPB_W-1:0]            i_Clks_Per_Bit,
  input  logic                        i_Parity_En,
  input  logic                        i_Parity_Odd,
  input  logic                        i_Two_Stop,
  output logic                        o_TX_Serial,
  output logic                        o_TX_Active,
  output logic                        o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0] o_FIFO_Count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 ready_q, ready_d;
  logic [CPB_W-1:0]     cnt_q, cnt_d, cpb_q, cpb_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_en_q, par_en_d, par_bit_q, par_bit_d, two_stop_q, two_stop_d;
  logic                 serial_q, serial_d, active_q, active_d, done_q, done_d;

  logic                 push, pop, bit_end, fifo_nonempty;
  logic [CPB_W-1:0]     cpb_in;
  logic [DATA_BITS-1:0] head;

  assign push          = i_TX_DV && ready_q;
  assign fifo_nonempty = (count_q != '0);
  assign head          = mem_q[rd_ptr_q];
  assign bit_end       = (cnt_q == cpb_q - CPB_W'(1));
  // Divisors below 2 would leave no room for a counted bit period.
  assign cpb_in        = (i_Clks_Per_Bit < CPB_W'(2)) ? CPB_W'(2) : i_Clks_Per_Bit;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      count_d = count_q + CntW'(1);
    else if (!push && pop) count_d = count_q - CntW'(1);
    ready_d = (count_d < CntW'(FIFO_DEPTH));
  end

  // Frame sequencing; a pop latches the head byte and the frame's config.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + CPB_W'(1);
    idx_d      = idx_q;
    stop_idx_d = stop_idx_q;
    shift_d    = shift_q;
    cpb_d      = cpb_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    done_d     = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        pop   = fifo_nonempty;
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          idx_d   = '0;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxW'(DATA_BITS - 1)) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (two_stop_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done_d = 1'b1;
            // Chain straight into the next start bit when more data waits.
            if (fifo_nonempty) pop = 1'b1;
            else               state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (pop) begin
      state_d    = StStart;
      cnt_d      = '0;
      stop_idx_d = 1'b0;
      shift_d    = head;
      cpb_d      = cpb_in;
      par_en_d   = i_Parity_En;
      par_bit_d  = (^head) ^ i_Parity_Odd;
      two_stop_d = i_Two_Stop;
    end
  end

  // Line level and activity follow the current state, one clock later.
  always_comb begin
    serial_d = 1'b1;
    case (state_q)
      StStart:  serial_d = 1'b0;
      StData:   serial_d = shift_q[0];
      StParity: serial_d = par_bit_q;
      default:  serial_d = 1'b1;
    endcase
    active_d = (state_q != StIdle);
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_TX_Byte;
  end

  // All state and registered outputs.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_q    <= 1'b1;
      cnt_q      <= '0;
      cpb_q      <= CPB_W'(2);
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      serial_q   <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_q    <= ready_d;
      cnt_q      <= cnt_d;
      cpb_q      <= cpb_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      serial_q   <= serial_d;
      active_q   <= active_d;
      done_q     <= done_d;
    end
  end

  assign o_TX_Serial  = serial_q;
  assign o_TX_Active  = active_q;
  assign o_TX_Done    = done_q;
  assign o_TX_Ready   = ready_q;
  assign o_FIFO_Count = count_q;

endmodule
